// File: rtl/mult_div_unit.sv
// Multicycle HI/LO multiply/divide unit.
// The result is computed and latched when the operation is accepted. It is committed to HI/LO
// after a fixed busy window, so the pipeline sees the latency it expects.
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  mdOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HIWrite,
   input  logic        LOWrite,
   input  logic        HIRead,
   input  logic        LORead,
   output logic        busy,
   output logic [31:0] out
);

   localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC + 1);

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;

   logic [31:0]   hi, lo;
   logic [31:0]   res_hi, res_lo;
   logic          dz;
   logic [CW-1:0] cnt;

   logic [63:0] prod_s, prod_u;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, b_u;
   logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
   logic [31:0] nxt_hi, nxt_lo;
   logic        accept;

   assign busy   = (cnt != '0);
   assign accept = start & ~busy;

   // Datapath: products and quotient/remainder of the operands currently presented.
   // Signed division goes through magnitudes so that 0x80000000 / -1 wraps to 0x80000000.
   // A zero divisor is replaced by 1 here; its result is discarded at completion.
   always_comb begin
      prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      prod_u = {32'h0, A} * {32'h0, B};
      a_neg  = A[31];
      b_neg  = B[31];
      a_mag  = a_neg ? (~A + 32'd1) : A;
      b_mag  = b_neg ? (~B + 32'd1) : B;
      if (B == '0) begin
         b_mag = 32'd1;
      end
      b_u    = (B == '0) ? 32'd1 : B;
      q_mag  = a_mag / b_mag;
      r_mag  = a_mag % b_mag;
      q_s    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      r_s    = a_neg ? (~r_mag + 32'd1) : r_mag;
      q_u    = A / b_u;
      r_u    = A % b_u;
      case (mdOp)
         OP_MULT:  begin nxt_hi = prod_s[63:32]; nxt_lo = prod_s[31:0]; end
         OP_MULTU: begin nxt_hi = prod_u[63:32]; nxt_lo = prod_u[31:0]; end
         OP_DIV:   begin nxt_hi = r_s;           nxt_lo = q_s;          end
         default:  begin nxt_hi = r_u;           nxt_lo = q_u;          end
      endcase
   end

   // Control and state: accept/countdown/commit, plus mthi/mtlo moves when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi     <= '0;
         lo     <= '0;
         res_hi <= '0;
         res_lo <= '0;
         dz     <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         res_hi <= nxt_hi;
         res_lo <= nxt_lo;
         dz     <= mdOp[1] & (B == '0);
         cnt    <= mdOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (busy) begin
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1) && !dz) begin
            hi <= res_hi;
            lo <= res_lo;
         end
      end else begin
         if (HIWrite) begin
            hi <= A;
         end
         if (LOWrite) begin
            lo <= A;
         end
      end
   end

   // Read port: HI takes priority over LO.
   always_comb begin
      if (HIRead) begin
         out = hi;
      end else if (LORead) begin
         out = lo;
      end else begin
         out = '0;
      end
   end

endmodule
